// File: rtl/fifo_uart_tx_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_if
// Read-port bundle between a synchronous FIFO and its UART drain stage.
//   fifo_empty : FIFO empty flag (FIFO -> drain)
//   fifo_data  : FIFO data_out, registered, valid the cycle after a pop edge
//   fifo_pop   : pop strobe (drain -> FIFO)
// Modports: master = drain stage (fifo_uart_tx), slave = FIFO read side.
// -----------------------------------------------------------------------------
interface fifo_uart_tx_if #(
   parameter int DATA_SIZE = 8
);
   logic                 fifo_empty;
   logic [DATA_SIZE-1:0] fifo_data;
   logic                 fifo_pop;

   modport master (
      input  fifo_empty,
      input  fifo_data,
      output fifo_pop
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      input  fifo_pop
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Drain stage for a synchronous FIFO: pops one word at a time and serialises
// it as a UART frame (start, DATA_SIZE data bits LSB first, optional even
// parity, stop). A pop is only issued after seeing the FIFO non-empty in IDLE.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   enable     : permits starting new frames (sampled in IDLE only)
//   fifo_rd    : FIFO read port (empty flag, registered data, pop strobe)
//   tx         : serial line, idle high
//   busy       : high in every state except IDLE
//   frame_done : one-cycle pulse on the last stop-bit cycle
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module fifo_uart_tx #(
   parameter int DATA_SIZE    = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter bit PARITY_EN    = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           enable,
   fifo_uart_tx_if.master fifo_rd,
   output logic           tx,
   output logic           busy,
   output logic           frame_done
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(DATA_SIZE) + 1;

   localparam logic [BAUD_W-1:0] BAUD_ZERO = '0;
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_ZERO  = '0;
   localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);

   // With one clock per bit the stop bit is also its own last cycle, so
   // frame_done must be raised on entry to STOP.
   localparam bit DONE_ON_ENTRY = (CLKS_PER_BIT == 1);

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t               state_reg;
   logic [BAUD_W-1:0]    baud_reg;
   logic [BIT_W-1:0]     bit_reg;
   logic [DATA_SIZE-1:0] shreg_reg;
   logic                 parity_reg;
   logic                 tx_reg;
   logic                 pop_reg;
   logic                 busy_reg;
   logic                 done_reg;

   logic                 baud_end;
   logic [BAUD_W-1:0]    baud_inc;
   logic [DATA_SIZE-1:0] shreg_shift;

   assign baud_end    = (baud_reg == BAUD_LAST);
   assign baud_inc    = baud_reg + BAUD_ONE;
   assign shreg_shift = shreg_reg >> 1;

   // Each transition also loads the output flops with the values that belong
   // to the destination state, which keeps the outputs Moore and registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         baud_reg   <= BAUD_ZERO;
         bit_reg    <= BIT_ZERO;
         shreg_reg  <= '0;
         parity_reg <= 1'b0;
         tx_reg     <= 1'b1;
         pop_reg    <= 1'b0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               tx_reg   <= 1'b1;
               done_reg <= 1'b0;
               baud_reg <= BAUD_ZERO;
               if (enable && !fifo_rd.fifo_empty) begin
                  state_reg <= POP;
                  pop_reg   <= 1'b1;
                  busy_reg  <= 1'b1;
               end
            end

            POP: begin
               // Single pop per frame; FIFO data appears during LOAD.
               state_reg <= LOAD;
               pop_reg   <= 1'b0;
               tx_reg    <= 1'b1;
            end

            LOAD: begin
               shreg_reg  <= fifo_rd.fifo_data;
               parity_reg <= ^fifo_rd.fifo_data;
               baud_reg   <= BAUD_ZERO;
               state_reg  <= START;
               tx_reg     <= 1'b0;
            end

            START: begin
               if (baud_end) begin
                  baud_reg  <= BAUD_ZERO;
                  bit_reg   <= BIT_ZERO;
                  state_reg <= DATA;
                  tx_reg    <= shreg_reg[0];
               end else begin
                  baud_reg <= baud_inc;
               end
            end

            DATA: begin
               if (baud_end) begin
                  baud_reg  <= BAUD_ZERO;
                  shreg_reg <= shreg_shift;
                  bit_reg   <= bit_reg + BIT_ONE;
                  if (bit_reg == BIT_LAST) begin
                     if (PARITY_EN) begin
                        state_reg <= PARITY;
                        tx_reg    <= parity_reg;
                     end else begin
                        state_reg <= STOP;
                        tx_reg    <= 1'b1;
                        done_reg  <= DONE_ON_ENTRY;
                     end
                  end else begin
                     tx_reg <= shreg_shift[0];
                  end
               end else begin
                  baud_reg <= baud_inc;
               end
            end

            PARITY: begin
               if (baud_end) begin
                  baud_reg  <= BAUD_ZERO;
                  state_reg <= STOP;
                  tx_reg    <= 1'b1;
                  done_reg  <= DONE_ON_ENTRY;
               end else begin
                  baud_reg <= baud_inc;
               end
            end

            STOP: begin
               tx_reg <= 1'b1;
               if (baud_end) begin
                  baud_reg  <= BAUD_ZERO;
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b0;
               end else begin
                  baud_reg <= baud_inc;
                  // Raise the pulse one edge early so it covers the final cycle.
                  done_reg <= (baud_inc == BAUD_LAST);
               end
            end

            default: begin
               state_reg <= IDLE;
               tx_reg    <= 1'b1;
               pop_reg   <= 1'b0;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_rd.fifo_pop = pop_reg;
   assign tx               = tx_reg;
   assign busy             = busy_reg;
   assign frame_done       = done_reg;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Two drain stages (index 0: no parity, index 1: even parity) each fed by a
// small FIFO model. A negedge monitor predicts every line cycle from the frame
// format of the word the scoreboard says should be popped next, and decodes
// the data bits mid-bit like a UART receiver.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

   localparam int DW    = 8;
   localparam int N     = 4;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       en       [2] = '{1'b0, 1'b0};
   logic       push_en  [2] = '{1'b0, 1'b0};
   logic [7:0] push_data[2] = '{8'h00, 8'h00};

   logic tx_w  [2];
   logic busy_w[2];
   logic fd_w  [2];
   logic pop_w [2];

   // FIFO model
   logic [7:0] mem   [2][DEPTH];
   logic [7:0] dout  [2] = '{8'h00, 8'h00};
   logic [2:0] rd_ptr[2] = '{3'd0, 3'd0};
   logic [2:0] wr_ptr[2] = '{3'd0, 3'd0};
   int         cnt   [2] = '{0, 0};
   logic       uflow [2] = '{1'b0, 1'b0};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         fifo_uart_tx_if #(.DATA_SIZE(DW)) rd_if ();
         assign rd_if.fifo_empty = (cnt[gi] == 0);
         assign rd_if.fifo_data  = dout[gi];
         assign pop_w[gi]        = rd_if.fifo_pop;

         fifo_uart_tx #(
            .DATA_SIZE   (DW),
            .CLKS_PER_BIT(N),
            .PARITY_EN   (gi == 1)
         ) dut (
            .clk       (clk),
            .rst       (rst),
            .enable    (en[gi]),
            .fifo_rd   (rd_if),
            .tx        (tx_w[gi]),
            .busy      (busy_w[gi]),
            .frame_done(fd_w[gi])
         );
      end
   endgenerate

   always @(posedge clk) begin
      for (int ii = 0; ii < 2; ii++) begin
         if (pop_w[ii]) begin
            if (cnt[ii] == 0) begin
               uflow[ii] <= 1'b1;
            end else begin
               dout[ii]   <= mem[ii][rd_ptr[ii]];
               rd_ptr[ii] <= rd_ptr[ii] + 3'd1;
            end
         end
         if (push_en[ii]) begin
            mem[ii][wr_ptr[ii]] <= push_data[ii];
            wr_ptr[ii]          <= wr_ptr[ii] + 3'd1;
         end
         cnt[ii] <= cnt[ii] + (push_en[ii] ? 1 : 0) - ((pop_w[ii] && cnt[ii] != 0) ? 1 : 0);
      end
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Expected line level k cycles after POP entry for word w.
   function automatic logic exp_tx(input logic [7:0] w, input int kk, input bit par);
      int         b;
      logic [7:0] t;
      if (kk < 2) return 1'b1;
      b = (kk - 2) / N;
      if (b == 0) return 1'b0;
      if (b <= DW) begin
         t = w >> (b - 1);
         return t[0];
      end
      if (par && b == DW + 1) return ^w;
      return 1'b1;
   endfunction

   // Scoreboard / monitor state
   logic [7:0] q0[$];
   logic [7:0] q1[$];
   logic       rst_eff = 1'b1;
   bit         in_frame[2] = '{1'b0, 1'b0};
   bit         want    [2] = '{1'b0, 1'b0};
   int         k       [2] = '{0, 0};
   int         pops    [2] = '{0, 0};
   int         last_fd [2] = '{-1, -1};
   logic [7:0] word    [2] = '{8'h00, 8'h00};
   logic [7:0] rx      [2] = '{8'h00, 8'h00};
   logic [7:0] rx_last [2] = '{8'h00, 8'h00};
   logic       par_bit [2] = '{1'b0, 1'b0};
   int         cyc = 0;

   always @(posedge clk) rst_eff <= rst;

   always @(negedge clk) begin
      for (int ii = 0; ii < 2; ii++) begin
         automatic bit i   = ii[0];
         automatic int L   = 2 + (2 + DW + ii) * N;
         automatic bit act = 1'b0;
         if (rst_eff) begin
            in_frame[i] = 1'b0;
            last_fd[i]  = -1;
            check("rst_tx", int'(tx_w[i]), 1);
            check("rst_busy", int'(busy_w[i]), 0);
            check("rst_pop", int'(pop_w[i]), 0);
            check("rst_done", int'(fd_w[i]), 0);
         end else begin
            check("pop", int'(pop_w[i]), int'(want[i]));
            if (!in_frame[i] && pop_w[i]) begin
               pops[i]++;
               if (last_fd[i] >= 0) check("idle_gap", int'(cyc - last_fd[i] >= 2), 1);
               if ((i == 1'b0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                  check("pop_with_no_data", 0, 1);
                  word[i] = 8'h00;
               end else if (i == 1'b0) begin
                  word[i] = q0.pop_front();
               end else begin
                  word[i] = q1.pop_front();
               end
               in_frame[i] = 1'b1;
               k[i]        = 0;
               rx[i]       = 8'h00;
            end
            if (in_frame[i]) begin
               act = 1'b1;
               check("tx", int'(tx_w[i]), int'(exp_tx(word[i], k[i], i)));
               check("busy", int'(busy_w[i]), 1);
               check("frame_done", int'(fd_w[i]), int'(k[i] == L - 1));
               if (k[i] >= 2 + N && k[i] < 2 + N * (1 + DW) && ((k[i] - 2) % N) == N / 2)
                  rx[i][3'((k[i] - 2) / N - 1)] = tx_w[i];
               if (k[i] == 2 + N * (1 + DW) + N / 2) par_bit[i] = tx_w[i];
               if (k[i] == L - 1) begin
                  in_frame[i] = 1'b0;
                  check("rx_word", int'(rx[i]), int'(word[i]));
                  rx_last[i] = rx[i];
                  last_fd[i] = cyc;
               end else begin
                  k[i]++;
               end
            end else begin
               check("idle_tx", int'(tx_w[i]), 1);
               check("idle_busy", int'(busy_w[i]), 0);
               check("idle_done", int'(fd_w[i]), 0);
            end
         end
         want[i] = !act && en[i] && (cnt[i] != 0) && !rst;
      end
      cyc++;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input bit i, input logic [7:0] d);
      int n = 0;
      while (cnt[i] >= DEPTH && n < 500) begin
         tick(1);
         n++;
      end
      if (n >= 500) check("push_timeout", 0, 1);
      push_en[i]   = 1'b1;
      push_data[i] = d;
      if (i == 1'b0) q0.push_back(d);
      else q1.push_back(d);
      tick(1);
      push_en[i] = 1'b0;
   endtask

   task automatic wait_drain(input bit i, input int maxc);
      int n = 0;
      while (!(cnt[i] == 0 && !in_frame[i] && !busy_w[i]) && n < maxc) begin
         tick(1);
         n++;
      end
      if (n >= maxc) check("drain_timeout", 0, 1);
   endtask

   int         p0;
   int         n;
   logic [7:0] w1, w2;

   initial begin
      tick(1);
      // Reset held with data waiting and enable high: nothing may move.
      en[0] = 1'b1;
      en[1] = 1'b1;
      push(1'b0, 8'h3C);
      push(1'b1, 8'hC3);
      tick(2);
      check("reset_no_pop0", pops[0], 0);
      check("reset_no_pop1", pops[1], 0);
      rst = 1'b0;
      wait_drain(1'b0, 300);
      wait_drain(1'b1, 300);

      // Single frames; the parity instance covers both parity values.
      push(1'b0, 8'hA5);
      push(1'b1, 8'h07);
      wait_drain(1'b0, 300);
      wait_drain(1'b1, 300);
      check("single_rx_a5", int'(rx_last[0]), 8'hA5);
      check("parity_07", int'(par_bit[1]), 1);
      push(1'b1, 8'hA5);
      wait_drain(1'b1, 300);
      check("parity_a5", int'(par_bit[1]), 0);
      check("parity_rx_a5", int'(rx_last[1]), 8'hA5);

      // Burst drain of a full FIFO.
      en[0] = 1'b0;
      for (int j = 0; j < 8; j++) push(1'b0, 8'(j));
      check("burst_full", cnt[0], 8);
      p0    = pops[0];
      en[0] = 1'b1;
      wait_drain(1'b0, 1000);
      check("burst_pops", pops[0] - p0, 8);
      check("burst_empty", cnt[0], 0);
      check("burst_last", int'(rx_last[0]), 7);
      check("no_underflow", int'(uflow[0]), 0);

      // Enable dropped during frame 2 of 4.
      en[0] = 1'b0;
      for (int j = 0; j < 4; j++) push(1'b0, 8'($urandom_range(0, 255)));
      p0    = pops[0];
      en[0] = 1'b1;
      n     = 0;
      while (pops[0] < p0 + 2 && n < 400) begin
         tick(1);
         n++;
      end
      if (n >= 400) check("gate_wait_timeout", 0, 1);
      tick(10);
      en[0] = 1'b0;
      n     = 0;
      while (busy_w[0] && n < 200) begin
         tick(1);
         n++;
      end
      tick(10);
      check("gate_pops", pops[0] - p0, 2);
      check("gate_left", cnt[0], 2);
      en[0] = 1'b1;
      wait_drain(1'b0, 400);
      check("gate_resume_pops", pops[0] - p0, 4);

      // Reset during data bit 3; aborted word is dropped.
      en[0] = 1'b0;
      w1    = 8'($urandom_range(0, 255));
      w2    = 8'($urandom_range(0, 255));
      push(1'b0, w1);
      push(1'b0, w2);
      p0    = pops[0];
      en[0] = 1'b1;
      n     = 0;
      while (!pop_w[0] && n < 50) begin
         tick(1);
         n++;
      end
      if (n >= 50) check("midrst_wait_timeout", 0, 1);
      tick(2 + 4 * N);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("midrst_tx", int'(tx_w[0]), 1);
      check("midrst_busy", int'(busy_w[0]), 0);
      wait_drain(1'b0, 300);
      check("midrst_pops", pops[0] - p0, 2);
      check("midrst_next_word", int'(rx_last[0]), int'(w2));

      // Random traffic on both instances.
      for (int it = 0; it < 80; it++) begin
         for (int j = 0; j < 2; j++) begin
            if ($urandom_range(0, 2) == 0 && cnt[j] < DEPTH) push(j[0], 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 7) == 0) en[j] = ~en[j];
         end
         tick($urandom_range(0, 12));
      end
      en[0] = 1'b1;
      en[1] = 1'b1;
      wait_drain(1'b0, 5000);
      wait_drain(1'b1, 5000);
      check("rand_queue0", q0.size(), 0);
      check("rand_queue1", q1.size(), 0);
      check("rand_uflow0", int'(uflow[0]), 0);
      check("rand_uflow1", int'(uflow[1]), 0);

      tick(5);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for the synchronous FIFO. It pops one word at a time from the FIFO read port and serialises it as an asynchronous UART frame: start bit, DATA_SIZE data bits LSB-first, optional even-parity bit, stop bit. It never pops an empty FIFO, so it cannot cause FIFO underflow.

Parameters:
DATA_SIZE, 8, word width; must match the FIFO DATA_SIZE.
CLKS_PER_BIT, 4, clk cycles per serial bit; must be >= 1.
PARITY_EN, 0, 1 inserts an even-parity bit between the data bits and the stop bit.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
enable  input  1  permits starting new frames
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_SIZE  FIFO data_out, registered; valid the cycle after a pop edge
fifo_pop  output  1  FIFO pop strobe, registered
tx  output  1  serial line, idle high
busy  output  1  high in every state except IDLE
frame_done  output  1  one-cycle pulse on the last stop-bit cycle

Behaviour:
- Reset (rst=1 sampled at a clk edge): state=IDLE, tx=1, fifo_pop=0, busy=0, frame_done=0, all counters 0. Takes effect on the same edge, including mid-frame; an aborted frame is not resumed.
- Moore FSM. Outputs are decoded from registered state, so they are glitch-free.
- IDLE: tx=1. If enable && !fifo_empty, go to POP; otherwise stay.
- POP: exactly one cycle, fifo_pop=1, tx=1. Always go to LOAD.
- LOAD: one cycle, tx=1. On the exiting edge: shift register <= fifo_data, parity <= ^fifo_data. Go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx=shreg[0]. Each bit lasts CLKS_PER_BIT cycles. At the end of each bit period, shift right and increment the bit counter. After DATA_SIZE bits, go to PARITY if PARITY_EN=1, else STOP.
- PARITY: tx=parity (XOR of the data bits, giving an even count of ones) for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. frame_done=1 on the final cycle only. Then go to IDLE.
- Baud counter:
  - width max(1, clog2(CLKS_PER_BIT)).
  - Counts 0..CLKS_PER_BIT-1; wraps to 0 at the end of each bit.
  - Cleared on entry to START.
- Bit counter: width clog2(DATA_SIZE)+1. Cleared on entry to DATA.
- Frame length: 1 + 1 + (2 + DATA_SIZE + PARITY_EN) * CLKS_PER_BIT cycles from POP entry to the IDLE return. The line is idle for at least 3 cycles (IDLE, POP, LOAD) between back-to-back frames.
- fifo_empty and enable are sampled only in IDLE.
  - Deasserting enable mid-frame completes the current frame; no new pop follows.
  - A FIFO becoming empty mid-frame has no effect on the current frame.
- fifo_pop is never asserted while fifo_empty=1 was sampled in IDLE, and never more than once per frame.
- Simultaneous upstream push while this block pops is handled by the FIFO. This block places no constraint on it.

Test Plan:
- Reset: hold rst=1 for 2 cycles with the FIFO non-empty and enable=1 -> tx=1, fifo_pop=0, busy=0, frame_done=0 throughout. No pop occurs.
- Single frame, defaults: push 0xA5, enable=1 ->
  - fifo_pop high exactly 1 cycle.
  - tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 with 4 cycles each, then 1 for 4 cycles.
  - frame_done pulses once, 42 cycles after POP entry.
  - A bench UART receiver decodes 0xA5.
- Parity, PARITY_EN=1: send 0x07 -> parity bit 1. Send 0xA5 -> parity bit 0. Frame is 46 cycles.
- Burst drain: push 0..7 (FIFO full), enable=1 ->
  - 8 frames decoded in order 0..7.
  - Exactly 8 fifo_pop pulses.
  - FIFO empty afterwards; FIFO underflow never asserts.
  - 3 idle-high cycles between consecutive frames.
- Enable gating: deassert enable during frame 2 of 4 -> frame 2 completes intact, no further pops, 2 words remain in the FIFO. Reasserting enable sends the remaining 2 words.
- Reset mid-frame: assert rst during DATA bit 3 -> on the next edge tx=1, busy=0, state IDLE. After rst release, the next FIFO word is sent as a full frame. The aborted word is not re-sent.
